// File: rtl/nn_pkg.sv
// Shared constants and types for the digit-recognition output stage.
package nn_pkg;

    localparam int OUTPUT_WIDTH = 26;
    localparam int NUM_CLASSES  = 10;
    localparam int CLASS_WIDTH  = $clog2(NUM_CLASSES);

    typedef logic signed [OUTPUT_WIDTH-1:0] neuron_sum_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/neuron_argmax.sv
// Sequential argmax over the ten neuron sums; result offered on a valid/ready port.
// Optional MAX_SCORE output is enabled by defining NEURON_ARGMAX_SCORE_EN.
module neuron_argmax
    import nn_pkg::*;
#(
    parameter int NUM_CLASSES  = nn_pkg::NUM_CLASSES,
    parameter int OUTPUT_WIDTH = nn_pkg::OUTPUT_WIDTH,
    parameter int CLASS_WIDTH  = nn_pkg::CLASS_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CLASSES*OUTPUT_WIDTH-1:0] IN_SUMS,
    input  logic                                IN_DONE,
    output logic [CLASS_WIDTH-1:0]              CLASS,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                overrun,
`ifdef NEURON_ARGMAX_SCORE_EN
    output logic [OUTPUT_WIDTH-1:0]             MAX_SCORE,
`endif
    output argmax_state_t                       dbg_state
);

    localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);

    // Handshake: out_valid holds with CLASS stable until a cycle where out_valid & out_ready.
    argmax_state_t                   r_state;
    logic                            r_done_q;
    logic signed [OUTPUT_WIDTH-1:0]  r_bank [NUM_CLASSES];
    logic [CLASS_WIDTH-1:0]          r_idx;
    logic [CLASS_WIDTH-1:0]          r_best_idx;
    logic signed [OUTPUT_WIDTH-1:0]  r_best_val;
    logic [CLASS_WIDTH-1:0]          r_class;
    logic                            r_overrun;
`ifdef NEURON_ARGMAX_SCORE_EN
    logic [OUTPUT_WIDTH-1:0]         r_score;
`endif

    logic                            w_start;
    logic                            w_capture;
    logic                            w_drop;
    logic signed [OUTPUT_WIDTH-1:0]  w_sum0;
    logic signed [OUTPUT_WIDTH-1:0]  w_cur;
    logic                            w_better;

    always_comb begin
        w_start   = IN_DONE & ~r_done_q;
        // A fresh capture is legal from IDLE or from HOLD in the same cycle the result is taken.
        w_capture = w_start & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready));
        w_drop    = w_start & ~w_capture;
        w_sum0    = IN_SUMS[OUTPUT_WIDTH-1:0];
        w_cur     = r_bank[r_idx];
        w_better  = w_cur > r_best_val;
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_bank[k] <= IN_SUMS[k*OUTPUT_WIDTH +: OUTPUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_done_q   <= 1'b0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_val <= '0;
            r_class    <= '0;
            r_overrun  <= 1'b0;
`ifdef NEURON_ARGMAX_SCORE_EN
            r_score    <= '0;
`endif
        end else begin
            r_done_q <= IN_DONE;
            if (w_capture) begin
                r_best_val <= w_sum0;
                r_best_idx <= '0;
                r_idx      <= CLASS_WIDTH'(1);
                r_state    <= ST_SCAN;
            end else begin
                case (r_state)
                    ST_SCAN: begin
                        if (w_better) begin
                            r_best_val <= w_cur;
                            r_best_idx <= r_idx;
                        end
                        r_idx <= r_idx + CLASS_WIDTH'(1);
                        // Last compare folds straight into the output registers.
                        if (r_idx == LAST_IDX) begin
                            r_class <= w_better ? r_idx : r_best_idx;
`ifdef NEURON_ARGMAX_SCORE_EN
                            r_score <= w_better ? w_cur : r_best_val;
`endif
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign CLASS     = r_class;
    assign out_valid = (r_state == ST_HOLD);
    assign overrun   = r_overrun;
    assign dbg_state = r_state;
`ifdef NEURON_ARGMAX_SCORE_EN
    assign MAX_SCORE = r_score;
`endif

endmodule

// File: tb/tb_neuron_argmax.sv
// Self-checking bench for neuron_argmax: directed patterns, random sums, overrun,
// back-to-back and mid-scan reset, all checked against a plain argmax model.
module tb_neuron_argmax;
  localparam int NC = 10;
  localparam int OW = 26;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NC*OW-1:0] in_sums;
  logic             in_done;
  logic             out_ready;
  logic [CW-1:0]    cls;
  logic             out_valid;
  logic             overrun;
  logic [1:0]       dbg_state;
`ifdef NEURON_ARGMAX_SCORE_EN
  logic [OW-1:0]    max_score;
`endif

  neuron_argmax dut (
    .clk       (clk),
    .rst       (rst),
    .IN_SUMS   (in_sums),
    .IN_DONE   (in_done),
    .CLASS     (cls),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
`ifdef NEURON_ARGMAX_SCORE_EN
    .MAX_SCORE (max_score),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [CW-1:0] exp_q[$];
  logic [OW-1:0] score_q[$];
  nn_pkg::neuron_sum_t m_sums[NC];

  // Winner is the first index holding the largest signed value.
  function automatic int ref_argmax();
    int best = 0;
    for (int k = 1; k < NC; k++) begin
      if (m_sums[k] > m_sums[best]) best = k;
    end
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_sums();
    for (int k = 0; k < NC; k++) in_sums[k*OW +: OW] = m_sums[k];
  endtask

  task automatic push_expected();
    int w;
    w = ref_argmax();
    exp_q.push_back(CW'(w));
    score_q.push_back(m_sums[w]);
  endtask

  task automatic rand_sums(input int mode);
    for (int k = 0; k < NC; k++) begin
      case (mode)
        0: m_sums[k] = OW'($urandom);
        1: m_sums[k] = OW'($urandom_range(0, 3));
        default: m_sums[k] = -OW'($urandom_range(1, 32'h1FFFFFF));
      endcase
    end
  endtask

  // Called at a negedge: lowers IN_DONE for one cycle, loads sums, raises IN_DONE.
  task automatic do_capture();
    in_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_sums();
    in_done = 1'b1;
  endtask

  // Counts rising edges until out_valid is seen (sampled on the falling edge).
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_done = 1'b0; out_ready = 1'b0; in_sums = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (cls !== 4'd0) begin n_err++; $display("FAIL reset_class: got %0d expected 0", cls); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
`ifdef NEURON_ARGMAX_SCORE_EN
    n_vec++; if (max_score !== '0) begin n_err++; $display("FAIL reset_score: got %h expected 0", max_score); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_patterns();
    int lat;
    logic [CW-1:0] ec;
    logic [OW-1:0] es;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < NC; k++) begin
        case (p)
          0: m_sums[k] = OW'(k * 32'h40000);
          1: m_sums[k] = (k == 3) ? -26'sd1 : -26'sh400000;
          default: m_sums[k] = (k == 2 || k == 7) ? 26'sh0FFFFFF : 26'sd0;
        endcase
      end
      push_expected();
      do_capture();
      wait_valid(lat);
      ec = exp_q.pop_front();
      es = score_q.pop_front();
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL pat%0d_latency: got %0d expected 10", p, lat); end
      n_vec++; if (cls !== ec) begin n_err++; $display("FAIL pat%0d_class: got %0d expected %0d", p, cls, ec); end
`ifdef NEURON_ARGMAX_SCORE_EN
      n_vec++; if (max_score !== es) begin n_err++; $display("FAIL pat%0d_score: got %h expected %h", p, max_score, es); end
`endif
      @(posedge clk);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pat%0d_valid_fall: got %0b expected 0", p, out_valid); end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [CW-1:0] ec;
    logic [OW-1:0] es;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_sums($urandom_range(0, 2));
      push_expected();
      do_capture();
      wait_valid(lat);
      ec = exp_q.pop_front();
      es = score_q.pop_front();
      n_vec++; if (lat !== 10) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected 10", i, lat); end
      n_vec++; if (cls !== ec) begin n_err++; $display("FAIL rnd%0d_class: got %0d expected %0d", i, cls, ec); end
`ifdef NEURON_ARGMAX_SCORE_EN
      n_vec++; if (max_score !== es) begin n_err++; $display("FAIL rnd%0d_score: got %h expected %h", i, max_score, es); end
`endif
      n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rnd%0d_overrun: got %0b expected 0", i, overrun); end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_overrun_hold();
    int lat;
    bit stable;
    logic [CW-1:0] ec;
    out_ready = 1'b0;
    rand_sums(0);
    push_expected();
    do_capture();
    wait_valid(lat);
    ec = exp_q.pop_front();
    void'(score_q.pop_front());
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL hold_latency: got %0d expected 10", lat); end
    // New inputs while holding must not disturb the registered result.
    in_done = 1'b0;
    rand_sums(0);
    set_sums();
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cls !== ec || out_valid !== 1'b1) stable = 1'b0;
    end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL hold_stable: got class %0d valid %0b expected class %0d valid 1", cls, out_valid, ec); end
    in_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL hold_overrun_set: got %0b expected 1", overrun); end
    n_vec++; if (cls !== ec || out_valid !== 1'b1) begin n_err++; $display("FAIL hold_after_drop: got class %0d valid %0b expected class %0d valid 1", cls, out_valid, ec); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got valid %0b expected 0", out_valid); end
    stable = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b0 || dbg_state !== 2'd0) stable = 1'b0;
    end
    n_vec++; if (stable !== 1'b1) begin n_err++; $display("FAIL hold_no_second: got valid %0b state %0d expected valid 0 state 0", out_valid, dbg_state); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL hold_overrun_sticky: got %0b expected 1", overrun); end
  endtask

  task automatic test_overrun_scan();
    int lat;
    logic [CW-1:0] ec;
    pulse_reset();
    out_ready = 1'b1;
    rand_sums(0);
    push_expected();
    do_capture();
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 3) in_done = 1'b0;
      if (lat == 5) in_done = 1'b1;
    end while (!out_valid && lat < 40);
    ec = exp_q.pop_front();
    void'(score_q.pop_front());
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL scan_drop_latency: got %0d expected 10", lat); end
    n_vec++; if (cls !== ec) begin n_err++; $display("FAIL scan_drop_class: got %0d expected %0d", cls, ec); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL scan_drop_overrun: got %0b expected 1", overrun); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [CW-1:0] ec;
    logic [OW-1:0] es;
    in_done = 1'b0;
    pulse_reset();
    out_ready = 1'b0;
    rand_sums(2);
    push_expected();
    do_capture();
    wait_valid(lat);
    ec = exp_q.pop_front();
    void'(score_q.pop_front());
    n_vec++; if (cls !== ec) begin n_err++; $display("FAIL b2b_first_class: got %0d expected %0d", cls, ec); end
    in_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rand_sums(0);
    set_sums();
    push_expected();
    in_done = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || dbg_state !== 2'd1) begin n_err++; $display("FAIL b2b_recapture: got valid %0b state %0d expected valid 0 state 1", out_valid, dbg_state); end
    wait_valid(lat);
    ec = exp_q.pop_front();
    es = score_q.pop_front();
    n_vec++; if (lat + 1 !== 10) begin n_err++; $display("FAIL b2b_latency: got %0d expected 10", lat + 1); end
    n_vec++; if (cls !== ec) begin n_err++; $display("FAIL b2b_second_class: got %0d expected %0d", cls, ec); end
`ifdef NEURON_ARGMAX_SCORE_EN
    n_vec++; if (max_score !== es) begin n_err++; $display("FAIL b2b_score: got %h expected %h", max_score, es); end
`endif
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %0b expected 0", overrun); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    logic [CW-1:0] ec;
    logic [OW-1:0] es;
    out_ready = 1'b1;
    rand_sums(0);
    do_capture();
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (cls !== 4'd0 || out_valid !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL midscan_outputs: got class %0d valid %0b overrun %0b expected 0 0 0", cls, out_valid, overrun); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL midscan_state: got %0d expected 0", dbg_state); end
`ifdef NEURON_ARGMAX_SCORE_EN
    n_vec++; if (max_score !== '0) begin n_err++; $display("FAIL midscan_score: got %h expected 0", max_score); end
`endif
    // IN_DONE stays high across reset, so the first cycle afterwards is an edge.
    rand_sums(1);
    set_sums();
    push_expected();
    rst = 1'b0;
    wait_valid(lat);
    ec = exp_q.pop_front();
    es = score_q.pop_front();
    n_vec++; if (lat !== 10) begin n_err++; $display("FAIL midscan_fresh_latency: got %0d expected 10", lat); end
    n_vec++; if (cls !== ec) begin n_err++; $display("FAIL midscan_fresh_class: got %0d expected %0d", cls, ec); end
`ifdef NEURON_ARGMAX_SCORE_EN
    n_vec++; if (max_score !== es) begin n_err++; $display("FAIL midscan_fresh_score: got %h expected %h", max_score, es); end
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_patterns();
    test_random();
    test_overrun_hold();
    test_overrun_scan();
    test_back_to_back();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
